// File: rtl/fpdiv_arb_pkg.sv
// Shared types and constants for the FP-divide request arbiter.
package fpdiv_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [31:0] FP_QNAN          = 32'h7FC0_0000;
  localparam int unsigned WAIT_MASK_CYCLES = 2;
endpackage

// File: rtl/fpdiv_arbiter_rr.sv
// N-input round-robin arbiter; the priority pointer advances past the
// winner only when update_en reports a completed handshake.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 update_en,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] idx_s;
  logic [IW-1:0] cand_s;
  logic          found_s;
  logic          hit_s;

  // Scan requesters starting at the pointer; first active one wins
  always_comb begin
    idx_s   = {IW{1'b0}};
    cand_s  = {IW{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s  = IW'((int'(ptr_r) + k) % N);
      hit_s   = ~found_s & req[cand_s];
      idx_s   = hit_s ? cand_s : idx_s;
      found_s = found_s | hit_s;
    end
  end

  assign grant     = found_s ? (N'(1) << idx_s) : {N{1'b0}};
  assign grant_idx = idx_s;

  // Priority pointer: next requester after the one just served
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= {IW{1'b0}};
    end else if (update_en) begin
      ptr_r <= (idx_s == IW'(N - 1)) ? {IW{1'b0}} : idx_s + IW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
endmodule

// File: rtl/fpdiv_arbiter.sv
// Round-robin front end sharing one FP divider among N_REQ requesters.
// Optional watchdog: define FPDIV_ARB_TIMEOUT_EN.
module fpdiv_arbiter
  import fpdiv_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic                     div_busy,
  input  logic                     div_valid,
  input  logic [WIDTH-1:0]         div_result
);
  localparam int IW = $clog2(N_REQ);

  state_e           state_r, state_nxt_s;
  logic [N_REQ-1:0] grant_s;
  logic [IW-1:0]    grant_idx_s;
  logic             hs_s;
  logic             capture_s;
  logic             timeout_s;
  logic             timeout_hit_s;
  logic             mask_done_s;
  logic [1:0]       mask_cnt_r;
  logic [WIDTH-1:0] a_r, b_r, a_sel_s, b_sel_s, data_r;
  logic [IW-1:0]    id_r;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .update_en (hs_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign req_ready   = (rst && state_r == ST_IDLE) ? grant_s : {N_REQ{1'b0}};
  assign hs_s        = |(req_valid & req_ready);
  assign mask_done_s = (mask_cnt_r == 2'(WAIT_MASK_CYCLES));

  // Operand mux keyed by the one-hot grant
  always_comb begin
    a_sel_s = {WIDTH{1'b0}};
    b_sel_s = {WIDTH{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      a_sel_s = a_sel_s | ({WIDTH{grant_s[k]}} & req_a[k*WIDTH +: WIDTH]);
      b_sel_s = b_sel_s | ({WIDTH{grant_s[k]}} & req_b[k*WIDTH +: WIDTH]);
    end
  end

  // Next-state decode; early div_valid is a leftover from the previous op
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) state_nxt_s = ST_ISSUE;
        else      state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (mask_done_s && div_valid && !div_busy) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else if (timeout_hit_s) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, latched request and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      id_r       <= {IW{1'b0}};
      data_r     <= {WIDTH{1'b0}};
      mask_cnt_r <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      if (hs_s) begin
        a_r  <= a_sel_s;
        b_r  <= b_sel_s;
        id_r <= grant_idx_s;
      end
      if (state_r == ST_ISSUE)
        mask_cnt_r <= 2'd0;
      else if (state_r == ST_WAIT && !mask_done_s)
        mask_cnt_r <= mask_cnt_r + 2'd1;
      if (capture_s)
        data_r <= div_result;
      else if (timeout_s)
        data_r <= WIDTH'(FP_QNAN);
    end
  end

`ifdef FPDIV_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_r;
  logic           err_r;

  assign timeout_hit_s = (wd_r == WDW'(TIMEOUT_CYCLES - 1));

  // Watchdog counts WAIT cycles of the current operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_r  <= {WDW{1'b0}};
      err_r <= 1'b0;
    end else begin
      if (hs_s)
        wd_r <= {WDW{1'b0}};
      else if (state_r == ST_WAIT && !timeout_hit_s)
        wd_r <= wd_r + WDW'(1);
      if (capture_s)
        err_r <= 1'b0;
      else if (timeout_s)
        err_r <= 1'b1;
    end
  end
  assign resp_err = err_r;
`else
  assign timeout_hit_s = 1'b0;
  assign resp_err      = 1'b0;
`endif

  assign resp_valid   = (state_r == ST_RESP);
  assign resp_id      = id_r;
  assign resp_data    = data_r;
  assign div_start    = (state_r == ST_ISSUE);
  assign div_dividend = (state_r == ST_ISSUE || state_r == ST_WAIT) ? a_r : {WIDTH{1'b0}};
  assign div_divisor  = (state_r == ST_ISSUE || state_r == ST_WAIT) ? b_r : {WIDTH{1'b0}};
endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Directed bench for fpdiv_arbiter with a behavioural shared-divider model.
module tb_fpdiv_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           resp_valid, resp_ready, resp_err;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_data;
  logic           div_start, div_busy, div_valid;
  logic [W-1:0]   div_dividend, div_divisor, div_result;

  int checks = 0, failures = 0;
  int onehot_err = 0, start_cnt = 0;
  int n, s0;
  logic hang;
  int   lat;
  logic [31:0] exp_q [4];

  always #5 clk = ~clk;

  fpdiv_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_valid(div_valid), .div_result(div_result)
  );

  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    if (b[30:0] == 31'd0) return 32'h7F80_0000;
    case ({a, b})
      64'h40C00000_40000000: return 32'h4040_0000;
      64'h41000000_40000000: return 32'h4080_0000;
      64'h3F800000_40800000: return 32'h3E80_0000;
      64'h41200000_40800000: return 32'h4020_0000;
      default:               return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Divider model: valid stays high (stale) until the next result lands
  logic        pend;
  int          cnt;
  logic [31:0] res_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_busy <= 1'b0; div_valid <= 1'b0; div_result <= 32'd0;
      pend <= 1'b0; cnt <= 0; res_q <= 32'd0;
    end else if (div_start) begin
      pend  <= 1'b1;
      res_q <= quot(div_dividend, div_divisor);
      if (hang) begin
        div_valid <= 1'b0; div_busy <= 1'b1; cnt <= 0;
      end else if (div_divisor[30:0] == 31'd0) begin
        cnt <= 1;
      end else begin
        div_busy <= 1'b1; cnt <= lat;
      end
    end else if (pend && !hang) begin
      if (cnt == 0) begin
        div_valid <= 1'b1; div_busy <= 1'b0; div_result <= res_q; pend <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  always @(negedge clk) if ($countones(req_ready) > 1) onehot_err++;
  always @(posedge clk) if (rst && div_start) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input string tag, output int cyc);
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 200) begin step(); cyc++; end
    chk({tag, "_resp_seen"}, {31'd0, resp_valid}, 32'd1);
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
    req_a[k*W +: W] = a;
    req_b[k*W +: W] = b;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  {28'd0, req_ready}, 32'd0);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_id"},    {30'd0, resp_id}, 32'd0);
    chk({tag, "_resp_data"},  resp_data, 32'd0);
    chk({tag, "_resp_err"},   {31'd0, resp_err}, 32'd0);
    chk({tag, "_div_start"},  {31'd0, div_start}, 32'd0);
    chk({tag, "_dividend"},   div_dividend, 32'd0);
    chk({tag, "_divisor"},    div_divisor, 32'd0);
  endtask

  initial begin
    exp_q[0] = 32'h4040_0000; exp_q[1] = 32'h4080_0000;
    exp_q[2] = 32'h3E80_0000; exp_q[3] = 32'h4020_0000;
    rst = 1'b0; req_valid = 4'b0001; req_a = '0; req_b = '0;
    resp_ready = 1'b1; hang = 1'b0; lat = 3;
    set_req(0, 32'h40C0_0000, 32'h4000_0000);
    #12;
    chk_reset_outputs("reset");

    // Single request 6.0 / 2.0 from requester 0
    @(negedge clk); rst = 1'b1; #1;
    chk("r0_grant", {28'd0, req_ready}, 32'h1);
    s0 = start_cnt;
    step();
    req_valid = 4'b0000;
    req_a[31:0] = 32'h1234_5678;
    chk("r0_start", {31'd0, div_start}, 32'd1);
    chk("r0_dividend", div_dividend, 32'h40C0_0000);
    chk("r0_divisor", div_divisor, 32'h4000_0000);
    wait_resp("r0", n);
    chk("r0_latency", n, 32'd6);
    chk("r0_id", {30'd0, resp_id}, 32'd0);
    chk("r0_data", resp_data, 32'h4040_0000);
    chk("r0_err", {31'd0, resp_err}, 32'd0);
    chk("r0_start_pulses", start_cnt - s0, 32'd1);
    step();
    chk("r0_done", {31'd0, resp_valid}, 32'd0);

    // All four requesters from reset: expect order 0,1,2,3
    @(negedge clk); rst = 1'b0;
    set_req(0, 32'h40C0_0000, 32'h4000_0000);
    set_req(1, 32'h4100_0000, 32'h4000_0000);
    set_req(2, 32'h3F80_0000, 32'h4080_0000);
    set_req(3, 32'h4120_0000, 32'h4080_0000);
    req_valid = 4'b1111;
    @(negedge clk); rst = 1'b1; #1;
    for (int k = 0; k < N; k++) begin
      n = 0;
      while (req_ready == 4'b0000 && n < 20) begin step(); n++; end
      chk($sformatf("rr_grant%0d", k), {28'd0, req_ready}, 32'd1 << k);
      step();
      req_valid[k] = 1'b0;
      wait_resp($sformatf("rr%0d", k), n);
      chk($sformatf("rr_id%0d", k), {30'd0, resp_id}, k);
      chk($sformatf("rr_data%0d", k), resp_data, exp_q[k]);
      step();
    end

    // 1.0 / 0.0 right after a completed op; hold response 10 cycles
    set_req(0, 32'h3F80_0000, 32'h0000_0000);
    req_valid = 4'b0001; #1;
    chk("dz_grant", {28'd0, req_ready}, 32'h1);
    step();
    req_valid = 4'b0000;
    resp_ready = 1'b0;
    chk("dz_start", {31'd0, div_start}, 32'd1);
    wait_resp("dz", n);
    chk("dz_latency", n, 32'd4);
    chk("dz_id", {30'd0, resp_id}, 32'd0);
    req_valid = 4'b0100; #1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold_valid%0d", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("hold_data%0d", i), resp_data, 32'h7F80_0000);
      chk($sformatf("hold_ready%0d", i), {28'd0, req_ready}, 32'd0);
      step();
    end
    req_valid = 4'b0000;
    resp_ready = 1'b1;
    step();
    chk("hold_release", {31'd0, resp_valid}, 32'd0);
    chk("withdrawn_no_grant", {28'd0, req_ready}, 32'd0);
    step();
    chk("withdrawn_no_start", {31'd0, div_start}, 32'd0);

    // Reset while waiting on the divider, then a normal request
    hang = 1'b1;
    set_req(1, 32'h4100_0000, 32'h4000_0000);
    req_valid = 4'b0010; #1;
    chk("wr_grant", {28'd0, req_ready}, 32'h2);
    step();
    req_valid = 4'b0000;
    repeat (5) step();
    chk("wr_dividend_held", div_dividend, 32'h4100_0000);
    #2;
    rst = 1'b0;
    set_req(3, 32'h4120_0000, 32'h4080_0000);
    req_valid = 4'b1000;
    #1;
    chk_reset_outputs("wr_reset");
    hang = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    chk("after_rst_grant", {28'd0, req_ready}, 32'h8);
    step();
    req_valid = 4'b0000;
    wait_resp("after_rst", n);
    chk("after_rst_id", {30'd0, resp_id}, 32'd3);
    chk("after_rst_data", resp_data, 32'h4020_0000);
    chk("after_rst_err", {31'd0, resp_err}, 32'd0);
    step();

    // Divider never answers
    hang = 1'b1;
    set_req(0, 32'h40C0_0000, 32'h4000_0000);
    req_valid = 4'b0001; #1;
    step();
    req_valid = 4'b0000;
`ifdef FPDIV_ARB_TIMEOUT_EN
    wait_resp("wd", n);
    chk("wd_latency", n, 32'd65);
    chk("wd_err", {31'd0, resp_err}, 32'd1);
    chk("wd_data", resp_data, 32'h7FC0_0000);
    step();
    hang = 1'b0;
`else
    repeat (80) step();
    chk("nowd_pending", {31'd0, resp_valid}, 32'd0);
    chk("nowd_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk); rst = 1'b0; hang = 1'b0;
    @(negedge clk); rst = 1'b1;
`endif

    chk("onehot_grants", onehot_err, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpdiv_arbiter.md
FPDIV_ARBITER -- requirements
Module: fpdiv_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 32, IEEE-754 single operand/result width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, watchdog limit in cycles per operation.
REQ-004 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, N_REQ, per-requester operation request.
REQ-007 SHALL have port req_ready, output, N_REQ, one-hot grant; the handshake completes when req_valid[i] && req_ready[i].
REQ-008 SHALL have port req_a, input, N_REQ*WIDTH, dividends, with slice i belonging to requester i.
REQ-009 SHALL have port req_b, input, N_REQ*WIDTH, divisors, with slice i belonging to requester i.
REQ-010 SHALL have port resp_valid, input-side-decoupled output, 1, result available.
REQ-011 SHALL have port resp_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port resp_id, output, $clog2(N_REQ), requester index of the result.
REQ-013 SHALL have port resp_data, output, WIDTH, quotient.
REQ-014 SHALL have port resp_err, output, 1, watchdog expiry flag.
REQ-015 SHALL have port div_start, output, 1, start pulse to the shared divider.
REQ-016 SHALL have port div_dividend, output, WIDTH, operand to the shared divider.
REQ-017 SHALL have port div_divisor, output, WIDTH, operand to the shared divider.
REQ-018 SHALL have port div_busy, input, 1, from the shared divider.
REQ-019 SHALL have port div_valid, input, 1, from the shared divider.
REQ-020 SHALL have port div_result, input, WIDTH, from the shared divider.

Function
REQ-021 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-022 In IDLE, SHALL assert req_ready for the round-robin winner among req_valid, combinationally; on handshake SHALL latch operands and id, then go to ISSUE.
REQ-023 Round-robin: after granting i, requester i+1 (mod N_REQ) SHALL have highest priority; the pointer SHALL update only on a completed handshake.
REQ-024 SHALL drive latched operands on div_dividend/div_divisor continuously from ISSUE through WAIT.
REQ-025 ISSUE SHALL last exactly 1 cycle with div_start=1, then go to WAIT.
REQ-026 In WAIT, SHALL ignore div_valid during the first 2 cycles (stale-valid masking).
REQ-027 In WAIT, from the third cycle on, div_valid=1 && div_busy=0 SHALL capture div_result into resp_data, set resp_err=0 and go to RESP.
REQ-028 In RESP, resp_valid=1 SHALL hold resp_id, resp_data and resp_err stable until resp_ready; on that cycle SHALL return to IDLE, and no grant SHALL occur in the same cycle.
REQ-029 req_ready SHALL be 0 in every state other than IDLE, giving at most one operation in flight.
REQ-030 A req_valid deasserted before handshake SHALL be legal and SHALL cause no grant.
REQ-031 SHALL have a minimum issue-to-resp_valid latency of 4 cycles for special operands, plus the divider compute time otherwise.

Reset
REQ-032 On rst=0, outputs SHALL take these values: state=IDLE, req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, div_start=0, div_dividend=0, div_divisor=0, RR pointer=0, watchdog=0.
REQ-033 Reset mid-operation SHALL abandon the operation with no response; the divider SHALL be reset by the same rst net (inverted at top level).

Configuration
REQ-034 With FPDIV_ARB_TIMEOUT_EN defined, a WAIT-cycle counter SHALL, on reaching TIMEOUT_CYCLES, set resp_data=32'h7FC00000 and resp_err=1 and go to RESP; the counter SHALL clear on entering ISSUE.
REQ-035 With FPDIV_ARB_TIMEOUT_EN undefined, the counter SHALL be absent, WAIT SHALL be unbounded, and resp_err SHALL be tied to 0.

Structure
REQ-036 The package fpdiv_arb_pkg SHALL hold the state enum, the FP_QNAN constant, and the WAIT_MASK_CYCLES=2 constant.
REQ-037 The sub-module rr_arbiter (N-input round-robin, with a pointer-update enable) SHALL be instantiated once.

Verification
REQ-038 Only requester 0 issues 6.0/2.0 (0x40C00000/0x40000000) -> one start pulse, then resp_id=0, resp_data=0x40400000, resp_err=0.
REQ-039 All 4 requesters valid simultaneously from reset -> grants in the order 0,1,2,3, each response id matching its grant, and never two req_ready bits set.
REQ-040 1.0/0.0 (divisor zero) -> resp_data=0x7F800000 with no busy phase, and the response is not taken from the stale valid of the previous operation.
REQ-041 resp_ready held low 10 cycles -> resp_valid/data stable for all 10 cycles, and no req_ready asserted.
REQ-042 rst asserted in WAIT -> all outputs at reset values in the same cycle, and the next request is serviced normally.
REQ-043 With FPDIV_ARB_TIMEOUT_EN defined and div_valid forced 0 -> after 64 WAIT cycles, resp_err=1 and resp_data=0x7FC00000.
